// File: rtl/ddr4_cmd_queue.sv
// ddr4_cmd_queue: host request FIFO and single-outstanding command sequencer
// placed in front of the DDR4 controller. Requests are queued and then issued
// one at a time as single-cycle write_en/read_en pulses. Read data is returned
// once the controller signals ready. The memory clock enable is dropped after
// the queue has been idle for CKE_IDLE cycles.
//
// Optional feature: define DDR4_CMDQ_TIMEOUT_EN to abort commands that wait
// TIMEOUT_CYCLES without mc_ready. An aborted command returns an error
// response (rsp_err=1, rsp_data=0). Without the macro, WAIT has no time limit
// and rsp_err is tied low.
module ddr4_cmd_queue #(
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned ISSUE_GAP      = 4,
  parameter int unsigned CKE_IDLE       = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [DATA_W-1:0]            req_wdata,
  output logic                         mc_write_en,
  output logic                         mc_read_en,
  output logic [ADDR_W-1:0]            mc_address,
  output logic [DATA_W-1:0]            mc_data_in,
  output logic                         mc_clk_enable,
  input  logic                         mc_ready,
  input  logic [DATA_W-1:0]            mc_rdata,
  output logic                         rsp_valid,
  output logic [DATA_W-1:0]            rsp_data,
  output logic                         rsp_err,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         busy
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = $clog2(DEPTH+1);
  localparam int unsigned GAP_W   = (ISSUE_GAP > 0) ? $clog2(ISSUE_GAP+1) : 1;
  localparam int unsigned IDLE_W  = (CKE_IDLE > 0) ? $clog2(CKE_IDLE+1) : 1;
  localparam int unsigned ENTRY_W = 1 + ADDR_W + DATA_W;

  // Elaboration-time parameter sanity checks
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("ddr4_cmd_queue: DEPTH must be a power of two >= 2");
  end
  if ((CKE_IDLE < 1) || (TIMEOUT_CYCLES < 1)) begin : g_bad_limits
    $error("ddr4_cmd_queue: CKE_IDLE and TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_GAP} state_t;

  state_t              state_q, state_d;
  logic [ENTRY_W-1:0]  mem_q [DEPTH];
  logic [ENTRY_W-1:0]  head;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                push, pop, full, empty, busy_w, complete;
  logic                cke_q, cke_d, cke_prev_q;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                cmd_write_q, cmd_write_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
`ifdef DDR4_CMDQ_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES+1);
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                rsp_err_q, rsp_err_d;
`endif

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign push      = req_valid && !full;
  assign busy_w    = (state_q != ST_IDLE) || !empty;
  // Issue only once the memory clock has been running for two cycles
  assign pop       = (state_q == ST_IDLE) && !empty && cke_q && cke_prev_q;
  assign head      = mem_q[rd_ptr_q];

  // Request storage: written on accepted push, head consumed on pop
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {req_write, req_addr, req_wdata};
    end
  end

  // FIFO pointer and occupancy update; pointers wrap naturally at DEPTH
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Clock-enable manager: on at push, off after CKE_IDLE idle cycles
  always_comb begin
    cke_d      = cke_q;
    idle_cnt_d = idle_cnt_q;
    if (push) begin
      cke_d      = 1'b1;
      idle_cnt_d = '0;
    end else if (busy_w) begin
      idle_cnt_d = '0;
    end else if (cke_q) begin
      if (idle_cnt_q == IDLE_W'(CKE_IDLE - 1)) begin
        cke_d      = 1'b0;
        idle_cnt_d = '0;
      end else begin
        idle_cnt_d = idle_cnt_q + IDLE_W'(1);
      end
    end
  end

  // Sequencer next-state, command capture and response generation
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cmd_write_d = cmd_write_q;
    gap_cnt_d   = gap_cnt_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    complete    = 1'b0;
`ifdef DDR4_CMDQ_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
    rsp_err_d   = rsp_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          {cmd_write_d, addr_d, wdata_d} = head;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // mc_ready during the issue cycle is deliberately not looked at
        state_d = ST_WAIT;
`ifdef DDR4_CMDQ_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      ST_WAIT: begin
        if (mc_ready) begin
          complete = 1'b1;
          if (!cmd_write_q) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = mc_rdata;
`ifdef DDR4_CMDQ_TIMEOUT_EN
            rsp_err_d   = 1'b0;
`endif
          end
        end
`ifdef DDR4_CMDQ_TIMEOUT_EN
        else if (wait_cnt_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
          complete    = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
`endif
      end
      ST_GAP: begin
        gap_cnt_d = gap_cnt_q - GAP_W'(1);
        if (gap_cnt_q <= GAP_W'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (complete) begin
      if (ISSUE_GAP == 0) begin
        state_d = ST_IDLE;
      end else begin
        state_d   = ST_GAP;
        gap_cnt_d = GAP_W'(ISSUE_GAP);
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cke_q       <= 1'b0;
      cke_prev_q  <= 1'b0;
      idle_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cmd_write_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
`ifdef DDR4_CMDQ_TIMEOUT_EN
      wait_cnt_q  <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cke_q       <= cke_d;
      cke_prev_q  <= cke_q;
      idle_cnt_q  <= idle_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cmd_write_q <= cmd_write_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
`ifdef DDR4_CMDQ_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign req_ready     = !full;
  assign mc_write_en   = (state_q == ST_ISSUE) && cmd_write_q;
  assign mc_read_en    = (state_q == ST_ISSUE) && !cmd_write_q;
  assign mc_address    = addr_q;
  assign mc_data_in    = wdata_q;
  assign mc_clk_enable = cke_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign count         = count_q;
  assign busy          = busy_w;
`ifdef DDR4_CMDQ_TIMEOUT_EN
  assign rsp_err       = rsp_err_q;
`else
  assign rsp_err       = 1'b0;
`endif

endmodule

// File: tb/tb_ddr4_cmd_queue.sv
// Directed testbench for ddr4_cmd_queue with hand-computed expectations.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_ddr4_cmd_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        mc_write_en, mc_read_en;
  logic [31:0] mc_address;
  logic [7:0]  mc_data_in;
  logic        mc_clk_enable;
  logic        mc_ready = 1'b0;
  logic [7:0]  mc_rdata = '0;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic [3:0]  count;
  logic        busy;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  ddr4_cmd_queue #(
    .DEPTH(8), .ADDR_W(32), .DATA_W(8), .ISSUE_GAP(4),
    .CKE_IDLE(16), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .mc_write_en(mc_write_en), .mc_read_en(mc_read_en),
    .mc_address(mc_address), .mc_data_in(mc_data_in),
    .mc_clk_enable(mc_clk_enable), .mc_ready(mc_ready), .mc_rdata(mc_rdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .count(count), .busy(busy)
  );

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_issue(input string tag);
    int n = 0;
    while (!(mc_read_en === 1'b1 || mc_write_en === 1'b1) && n < 40) begin
      cyc();
      n++;
    end
    chk({tag, "_issue_seen"}, 64'(n < 40), 64'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 80) begin
      cyc();
      n++;
    end
    chk({tag, "_idle_reached"}, 64'(n < 80), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---- Reset, then 20 idle cycles ----
    cyc(); cyc();
    reset = 1'b0;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_wr_en", 64'(mc_write_en), 64'd0);
    chk("rst_rd_en", 64'(mc_read_en), 64'd0);
    chk("rst_addr", 64'(mc_address), 64'd0);
    chk("rst_wdata", 64'(mc_data_in), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("idle_cke_low", 64'(mc_clk_enable), 64'd0);
    end
    chk("idle_busy", 64'(busy), 64'd0);

    // ---- Write 0x10/0xA5 with clock enable starting from off ----
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_wdata = 8'hA5;
    cyc(); // c1
    req_valid = 1'b0;
    chk("wr_cke_rise", 64'(mc_clk_enable), 64'd1);
    chk("wr_count1", 64'(count), 64'd1);
    chk("wr_busy", 64'(busy), 64'd1);
    cyc(); // c2: clock enable only one cycle old, no issue yet
    chk("wr_not_early", 64'(mc_write_en), 64'd0);
    cyc(); // c3: issue
    chk("wr_en_pulse", 64'(mc_write_en), 64'd1);
    chk("wr_no_rd_en", 64'(mc_read_en), 64'd0);
    chk("wr_addr", 64'(mc_address), 64'h10);
    chk("wr_data", 64'(mc_data_in), 64'hA5);
    chk("wr_popped", 64'(count), 64'd0);
    // queue the read 0x20 behind the write
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h20; req_wdata = 8'h00;
    cyc(); // c4
    req_valid = 1'b0;
    chk("wr_en_single", 64'(mc_write_en), 64'd0);
    chk("wr_addr_held", 64'(mc_address), 64'h10);
    chk("rd_queued", 64'(count), 64'd1);
    cyc(); // c5
    cyc(); // c6
    mc_ready = 1'b1;
    cyc(); // c7: first GAP cycle
    mc_ready = 1'b0;
    chk("wr_no_rsp", 64'(rsp_valid), 64'd0);
    chk("gap_no_issue_c7", 64'(mc_read_en), 64'd0);
    for (int i = 0; i < 4; i++) begin // c8..c11
      cyc();
      chk("gap_no_issue", 64'(mc_read_en), 64'd0);
    end
    cyc(); // c12: read issues after 4 gap cycles plus one idle cycle
    chk("rd_issue_after_gap", 64'(mc_read_en), 64'd1);
    chk("rd_addr", 64'(mc_address), 64'h20);
    chk("rd_no_wr_en", 64'(mc_write_en), 64'd0);
    mc_ready = 1'b1; mc_rdata = 8'hEE; // must be ignored during ISSUE
    cyc(); // c13
    mc_ready = 1'b0; mc_rdata = 8'h00;
    chk("issue_ready_ignored_a", 64'(rsp_valid), 64'd0);
    cyc(); // c14
    chk("issue_ready_ignored_b", 64'(rsp_valid), 64'd0);
    mc_ready = 1'b1; mc_rdata = 8'h3C;
    cyc(); // c15
    mc_ready = 1'b0; mc_rdata = 8'h00;
    chk("rd_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("rd_rsp_data", 64'(rsp_data), 64'h3C);
    chk("rd_rsp_err", 64'(rsp_err), 64'd0);
    cyc(); // c16
    chk("rd_rsp_one_pulse", 64'(rsp_valid), 64'd0);
    chk("rd_rsp_data_hold", 64'(rsp_data), 64'h3C);

    // ---- 9 back-to-back reads with mc_ready low ----
    wait_idle("fill_start");
    for (int j = 0; j < 9; j++) begin
      chk("fill_ready", 64'(req_ready), 64'd1);
      if (j == 2) begin
        chk("fill_first_issue_t2", 64'(mc_read_en), 64'd1);
        chk("fill_first_addr", 64'(mc_address), 64'h100);
      end
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h100 + 32'(j); req_wdata = 8'h00;
      cyc();
    end
    chk("full_ready_low", 64'(req_ready), 64'd0);
    chk("full_count8", 64'(count), 64'd8);
    req_addr = 32'h1FF; // attempt while full must be refused
    cyc();
    req_valid = 1'b0;
    chk("full_push_refused", 64'(count), 64'd8);
    mc_ready = 1'b1; mc_rdata = 8'h40;
    cyc();
    mc_ready = 1'b0;
    chk("drain0_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("drain0_rsp_data", 64'(rsp_data), 64'h40);
    for (int i = 1; i < 9; i++) begin
      wait_issue("drain");
      chk("drain_rd_en", 64'(mc_read_en), 64'd1);
      chk("drain_addr_order", 64'(mc_address), 64'h100 + 64'(i));
      cyc();
      mc_ready = 1'b1; mc_rdata = 8'h40 + 8'(i);
      cyc();
      mc_ready = 1'b0;
      chk("drain_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("drain_rsp_data", 64'(rsp_data), 64'h40 + 64'(i));
    end
    chk("drain_count0", 64'(count), 64'd0);
    wait_idle("cke");
    chk("cke_idle_start", 64'(mc_clk_enable), 64'd1);
    for (int i = 0; i < 15; i++) cyc();
    chk("cke_still_on_15", 64'(mc_clk_enable), 64'd1);
    cyc();
    chk("cke_off_16", 64'(mc_clk_enable), 64'd0);

`ifdef DDR4_CMDQ_TIMEOUT_EN
    // ---- Read with mc_ready held low times out ----
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'hAB0;
    cyc();
    req_valid = 1'b0;
    wait_issue("tmo");
    for (int k = 0; k < 64; k++) cyc();
    chk("tmo_not_early", 64'(rsp_valid), 64'd0);
    cyc();
    chk("tmo_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("tmo_rsp_err", 64'(rsp_err), 64'd1);
    chk("tmo_rsp_data", 64'(rsp_data), 64'd0);
    wait_idle("tmo");
`endif

    // ---- Reset during WAIT of a read ----
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h30;
    cyc();
    req_valid = 1'b0;
    wait_issue("rstw");
    chk("rstw_rd_en", 64'(mc_read_en), 64'd1);
    cyc(); // WAIT
    reset = 1'b1; mc_ready = 1'b1; mc_rdata = 8'h77;
    cyc();
    reset = 1'b0;
    chk("rstw_no_rsp", 64'(rsp_valid), 64'd0);
    chk("rstw_count0", 64'(count), 64'd0);
    chk("rstw_idle", 64'(busy), 64'd0);
    chk("rstw_cke_off", 64'(mc_clk_enable), 64'd0);
    chk("rstw_addr_clr", 64'(mc_address), 64'd0);
    cyc();
    mc_ready = 1'b0; mc_rdata = 8'h00;
    chk("rstw_no_rsp_after", 64'(rsp_valid), 64'd0);
    chk("rstw_no_reissue", 64'(mc_read_en), 64'd0);
    chk("rstw_still_idle", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
